// File: rtl/rand_num_gen_pkg.sv
// rand_num_gen_pkg: shared LFSR tap table (widths 4..16) and draw FSM states.
package rand_num_gen_pkg;

    typedef enum logic {IDLE, DRAW} state_t;

    // Maximal-length Fibonacci taps, bit positions are 0-based.
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

endpackage

// File: rtl/rand_num_gen_lfsr_core.sv
// lfsr_core: shift-left Fibonacci LFSR with synchronous load.
//   clk, reset (async, active-high) | enable: advance | load/load_val: parallel load | q: state
module lfsr_core
    import rand_num_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);
    localparam logic [15:0]      TAPS16 = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];

    logic fb;

    assign fb = ^(q & TAPS);

    always_ff @(posedge clk or posedge reset)
        if (reset)
            q <= WIDTH'(SEED);
        else if (load)
            q <= load_val;
        else if (enable)
            q <= {q[WIDTH-2:0], fb};

endmodule

// File: rtl/rand_num_gen.sv
// rand_num_gen: bounded random draws from a free-running LFSR via rejection sampling.
//   clk, reset (async, active-high) | enable: advance/evaluate | seed_load, seed: reseed
//   req, limit: request a draw in [0, limit) (limit 0 = full range)
//   raw: LFSR state | num/valid: registered result and its one-cycle strobe | busy: drawing
module rand_num_gen
    import rand_num_gen_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SEED      = 1,
    parameter int MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] num,
    output logic             valid,
    output logic             busy
);
    state_t           state;
    logic [3:0]       tries;
    logic [WIDTH-1:0] lim, mask, cand, load_val;
    logic             accept;

    // A zero seed would lock the LFSR, so it falls back to SEED.
    assign load_val = (seed == '0) ? WIDTH'(SEED) : seed;

    lfsr_core #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .load     (seed_load),
        .load_val (load_val),
        .q        (raw)
    );

    // Smear limit-1 rightwards to get the smallest all-ones mask covering it;
    // limit 0 wraps to all ones, i.e. the full range.
    always_comb begin
        mask = lim - 1'b1;
        for (int i = 1; i < WIDTH; i++)
            mask = mask | (mask >> i);
        cand   = raw & mask;
        accept = (lim == '0) || (cand < lim);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            tries <= '0;
            lim   <= '0;
            num   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE:
                    if (req && enable && !seed_load) begin
                        state <= DRAW;
                        busy  <= 1'b1;
                        lim   <= limit;
                        tries <= '0;
                    end
                DRAW:
                    if (enable) begin
                        // mask < 2*limit, so candidate-limit always lands below limit
                        if (accept || tries == 4'(MAX_TRIES - 1)) begin
                            num   <= accept ? cand : cand - lim;
                            valid <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else
                            tries <= tries + 4'd1;
                    end
                default:
                    state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_rand_num_gen.sv
module tb_rand_num_gen;
    logic       clk = 1'b0;
    logic       reset, enable, seed_load, req;
    logic [7:0] seed, limit;
    logic [7:0] raw, num, raw1, num1;
    logic       valid, busy, valid1, busy1;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    rand_num_gen #(.WIDTH(8), .SEED(1), .MAX_TRIES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
        .req(req), .limit(limit), .raw(raw), .num(num), .valid(valid), .busy(busy)
    );

    rand_num_gen #(.WIDTH(8), .SEED(1), .MAX_TRIES(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
        .req(req), .limit(limit), .raw(raw1), .num(num1), .valid(valid1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic reseed(input logic [7:0] s);
        seed_load = 1'b1;
        seed = s;
        step();
        seed_load = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [4];
        bit         zero_seen;
        int         nvalid, wait_cnt;
        seq = '{8'h02, 8'h04, 8'h08, 8'h11};
        reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = 8'h00; req = 1'b0; limit = 8'h00;
        #3;
        chk("reset_raw", raw, 8'h01);
        chk("reset_num", num, 8'h00);
        chk("reset_valid", valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        step(); step();
        reset = 1'b0;
        enable = 1'b1;

        zero_seen = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (raw == 8'h00) zero_seen = 1'b1;
            if (i <= 4) chk($sformatf("lfsr_seq%0d", i), raw, seq[i-1]);
            if (i == 254) chk("lfsr_not_early", raw == 8'h01, 1'b0);
        end
        chk("lfsr_period", raw, 8'h01);
        chk("lfsr_no_zero", zero_seen, 1'b0);

        reseed(8'h00);
        chk("seed_zero", raw, 8'h01);
        reseed(8'h81);
        chk("seed_81", raw, 8'h81);
        step();
        chk("seed_81_next", raw, 8'h03);

        // seed_load wins over req
        seed_load = 1'b1; seed = 8'h01; req = 1'b1; limit = 8'd6;
        step();
        seed_load = 1'b0; req = 1'b0;
        chk("req_with_load_busy", busy, 1'b0);

        // first-candidate accept: seed 0x01, limit 6
        reseed(8'h01);
        req = 1'b1; limit = 8'd6;
        step();
        req = 1'b0;
        chk("acc_raw", raw, 8'h02);
        chk("acc_busy", busy, 1'b1);
        chk("acc_valid_early", valid, 1'b0);
        step();
        chk("acc_valid", valid, 1'b1);
        chk("acc_num", num, 8'd2);
        chk("acc_busy_done", busy, 1'b0);
        step();
        chk("acc_valid_pulse", valid, 1'b0);
        chk("acc_num_hold", num, 8'd2);

        // one rejection then accept; MAX_TRIES=1 instance falls back
        reseed(8'h81);
        req = 1'b1; limit = 8'd3;
        step();
        req = 1'b0;
        chk("rej_raw", raw, 8'h03);
        step();
        chk("rej_valid_early", valid, 1'b0);
        chk("rej_busy", busy, 1'b1);
        chk("fb1_valid", valid1, 1'b1);
        chk("fb1_num", num1, 8'd0);
        step();
        chk("rej_valid", valid, 1'b1);
        chk("rej_num", num, 8'd2);

        // limit 0 takes the full value; limit 1 always yields 0
        reseed(8'h81);
        req = 1'b1; limit = 8'd0;
        step();
        req = 1'b0;
        step();
        chk("lim0_valid", valid, 1'b1);
        chk("lim0_num", num, 8'h03);
        reseed(8'h81);
        req = 1'b1; limit = 8'd1;
        step();
        req = 1'b0;
        step();
        chk("lim1_valid", valid, 1'b1);
        chk("lim1_num", num, 8'd0);

        // 5-cycle stall mid-draw
        reseed(8'h81);
        req = 1'b1; limit = 8'd3;
        step();
        req = 1'b0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall_raw%0d", i), raw, 8'h03);
            chk($sformatf("stall_busy%0d", i), busy, 1'b1);
            chk($sformatf("stall_valid%0d", i), valid, 1'b0);
        end
        enable = 1'b1;
        step();
        chk("stall_rej_valid", valid, 1'b0);
        chk("stall_rej_raw", raw, 8'h06);
        step();
        chk("stall_valid", valid, 1'b1);
        chk("stall_num", num, 8'd2);

        // req while busy is ignored
        reseed(8'h81);
        req = 1'b1; limit = 8'd3;
        step();
        step();
        chk("busy_req_ignored_busy", busy, 1'b1);
        step();
        req = 1'b0;
        chk("busy_req_valid", valid, 1'b1);
        step();
        chk("busy_req_no_second", busy, 1'b0);
        chk("busy_req_no_second_valid", valid, 1'b0);

        // reset mid-draw
        reseed(8'h81);
        req = 1'b1; limit = 8'd3;
        step();
        req = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_raw", raw, 8'h01);
        chk("mid_reset_num", num, 8'd0);
        step();
        reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (valid) nvalid++;
        end
        chk("mid_reset_no_valid", nvalid, 0);

        // random bounded draws
        nvalid = 0;
        for (int d = 0; d < 300; d++) begin
            limit = 8'($urandom_range(1, 255));
            req = 1'b1;
            step();
            req = 1'b0;
            wait_cnt = 0;
            while (!valid && wait_cnt < 8) begin
                step();
                wait_cnt++;
            end
            if (valid) begin
                nvalid++;
                if (!(num < limit)) chk($sformatf("rand_bound%0d", d), num, limit - 8'd1);
            end else
                chk($sformatf("rand_timeout%0d", d), valid, 1'b1);
            step();
            if (valid) chk($sformatf("rand_extra_valid%0d", d), valid, 1'b0);
        end
        chk("rand_valid_count", nvalid, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
